// File: rtl/network_config_pkg.sv
// network_config: shape of the spiking network core as seen by its consumers.
package network_config;

    // Number of output neurons, i.e. width of the net_out spike vector.
    localparam int unsigned NET_NUM_OUT = 4;

endpackage : network_config

// File: rtl/sink_config_pkg.sv
// sink_config: word layout shared by the buffered network sink and its users.
// Build option: define SNK_RLE_EN to enable zero-run compression, which
// prepends a run field to every sink word.
`ifndef SNK_WIDTH
`define SNK_WIDTH sink_config::SNK_WORD_WIDTH
`endif

package sink_config;
    import network_config::*;

`ifdef SNK_RLE_EN
    localparam bit SNK_RLE_ON = 1'b1;
`else
    localparam bit SNK_RLE_ON = 1'b0;
`endif

    // Default build-time sizes; the sink top exposes them as overridable parameters.
    localparam int unsigned SNK_RUN_WIDTH_DEF  = 8;
    localparam int unsigned SNK_FIFO_DEPTH_DEF = 16;

    localparam int unsigned SNK_OPC_WIDTH  = 0;
    localparam int unsigned SNK_SPK_WIDTH  = NET_NUM_OUT;
    // Run field only exists in the compressed format.
    localparam int unsigned SNK_WORD_WIDTH = SNK_SPK_WIDTH + (SNK_RLE_ON ? SNK_RUN_WIDTH_DEF : 0);

    typedef logic [SNK_WORD_WIDTH-1:0] snk_word_t;

endpackage : sink_config

// File: rtl/sink_fifo.sv
// sink_fifo: first-word fall-through FIFO with a registered head word.
// Storage is a plain array written on push and read through a register, so it
// maps onto block RAM; a push into an empty (or emptying) FIFO bypasses the
// array straight into the head register.
module sink_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         arstn,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW:0]      w_rd_next;
    logic [AW:0]      w_count;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A push is refused when full even if a pop frees a slot this cycle.
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_rd_next = w_pop_ok ? (r_rd_ptr + 1'b1) : r_rd_ptr;
    assign w_count   = r_wr_ptr - r_rd_ptr;

    // Array write port; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    // Pointer update on accepted push/pop.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
        end
    end

    // Head register: next read address, or the incoming word when it becomes the head.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_head <= '0;
        end else if (w_push_ok && (w_rd_next == r_wr_ptr)) begin
            r_head <= i_din;
        end else begin
            r_head <= r_mem[w_rd_next[AW-1:0]];
        end
    end

    assign o_dout  = r_head;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = LVL_W'(w_count);

endmodule : sink_fifo

// File: rtl/buffered_network_sink.sv
// buffered_network_sink: takes one spike vector per network handshake,
// bit-reverses it into sink order (neuron 0 in the MSB) and queues it for the
// host link. Build option SNK_RLE_EN collapses runs of all-zero vectors into
// a run count carried in the MSBs of the next word; flush drains a pending run.
module buffered_network_sink
    import network_config::*;
    import sink_config::*;
#(
    parameter int unsigned SNK_RUN_WIDTH  = SNK_RUN_WIDTH_DEF,
    parameter int unsigned SNK_FIFO_DEPTH = SNK_FIFO_DEPTH_DEF
) (
    input  logic                                              clk,
    input  logic                                              arstn,
    input  logic                                              net_valid,
    output logic                                              net_ready,
    input  logic [NET_NUM_OUT-1:0]                            net_out,
    input  logic                                              flush,
    input  logic                                              snk_ready,
    output logic                                              snk_valid,
    output logic [NET_NUM_OUT+(SNK_RLE_ON ? SNK_RUN_WIDTH : 0)-1:0] snk,
    output logic [$clog2(SNK_FIFO_DEPTH+1)-1:0]               snk_level
);
    localparam int unsigned W = NET_NUM_OUT + (SNK_RLE_ON ? SNK_RUN_WIDTH : 0);

    logic [NET_NUM_OUT-1:0] w_spk;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_push;
    logic [W-1:0]           w_din;

    // Sink order is the reverse of neuron order.
    generate
        for (genvar gi = 0; gi < NET_NUM_OUT; gi++) begin : g_rev
            assign w_spk[NET_NUM_OUT-1-gi] = net_out[gi];
        end
    endgenerate

    // Ready ignores net_valid so the core can rely on it without a loop.
    assign net_ready = !w_full && !flush;
    assign w_accept  = net_valid && net_ready;

`ifdef SNK_RLE_EN
    localparam logic [SNK_RUN_WIDTH-1:0] ZRUN_MAX = '1;

    logic [SNK_RUN_WIDTH-1:0] r_zrun;
    logic [SNK_RUN_WIDTH-1:0] w_zrun_next;

    // Run-length decision: push a word, or absorb a zero vector into the run.
    always_comb begin
        w_push      = 1'b0;
        w_din       = {r_zrun, w_spk};
        w_zrun_next = r_zrun;
        if (w_accept) begin
            if (w_spk != '0) begin
                w_push      = 1'b1;
                w_din       = {r_zrun, w_spk};
                w_zrun_next = '0;
            end else if (r_zrun != ZRUN_MAX) begin
                w_zrun_next = r_zrun + 1'b1;
            end else begin
                // Saturated run: this word stands for MAX+1 zero timesteps.
                w_push      = 1'b1;
                w_din       = {ZRUN_MAX, {NET_NUM_OUT{1'b0}}};
                w_zrun_next = '0;
            end
        end else if (flush && (r_zrun != '0) && !w_full) begin
            // The emitted zero word itself counts as one of the pending zeros.
            w_push      = 1'b1;
            w_din       = {r_zrun - 1'b1, {NET_NUM_OUT{1'b0}}};
            w_zrun_next = '0;
        end
    end

    // Zero-run counter.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_zrun <= '0;
        end else begin
            r_zrun <= w_zrun_next;
        end
    end
`else
    assign w_push = w_accept;
    assign w_din  = w_spk;
`endif

    sink_fifo #(
        .WIDTH (W),
        .DEPTH (SNK_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arstn   (arstn),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (snk_valid && snk_ready),
        .o_dout  (snk),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (snk_level)
    );

    assign snk_valid = !w_empty;

endmodule : buffered_network_sink

// File: tb/tb_buffered_network_sink.sv
// Directed bench for buffered_network_sink with 4 outputs, 2-bit runs and a
// 4-deep FIFO. Run-length cases are included when SNK_RLE_EN is defined.
module tb_buffered_network_sink;

`ifdef SNK_RLE_EN
    localparam bit RLE = 1'b1;
`else
    localparam bit RLE = 1'b0;
`endif
    localparam int W = 4 + (RLE ? 2 : 0);

    logic         clk;
    logic         arstn;
    logic         net_valid;
    logic         net_ready;
    logic [3:0]   net_out;
    logic         flush;
    logic         snk_ready;
    logic         snk_valid;
    logic [W-1:0] snk;
    logic [2:0]   snk_level;

    int n_checks = 0;
    int n_errors = 0;

    buffered_network_sink #(
        .SNK_RUN_WIDTH  (2),
        .SNK_FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .net_valid (net_valid),
        .net_ready (net_ready),
        .net_out   (net_out),
        .flush     (flush),
        .snk_ready (snk_ready),
        .snk_valid (snk_valid),
        .snk       (snk),
        .snk_level (snk_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] vec);
        net_valid = 1'b1;
        net_out   = vec;
        $display("send net_out=%b at %0t", vec, $time);
        tick();
        net_valid = 1'b0;
        net_out   = 4'b0000;
    endtask

    logic [3:0] exp_q [5];
    int         idx;
    logic       accepted;

    initial begin
        exp_q = '{4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b1010};
        arstn = 1'b0; net_valid = 1'b0; net_out = 4'b0000; flush = 1'b0; snk_ready = 1'b0;
        #3;
        check("rst_snk_valid", 32'(snk_valid), 32'd0);
        check("rst_level",     32'(snk_level), 32'd0);
        check("rst_net_ready", 32'(net_ready), 32'd1);
        check("rst_snk",       32'(snk),       32'd0);
        tick(); tick();
        arstn = 1'b1;
        tick();

        // Pass-through: neuron 0 lands in the MSB, one cycle latency.
        snk_ready = 1'b1;
        send(4'b0001);
        check("pt_valid", 32'(snk_valid), 32'd1);
        check("pt_snk",   32'(snk),       32'b1000);
        check("pt_level", 32'(snk_level), 32'd1);
        tick();
        check("pt_level_after", 32'(snk_level), 32'd0);
        check("pt_valid_after", 32'(snk_valid), 32'd0);

        // Backpressure: four fit, the fifth is held off until a word drains.
        snk_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            net_valid = 1'b1;
            net_out   = 4'(k + 1);
            #1;
            if (k < 4) begin
                check("bp_ready", 32'(net_ready), 32'd1);
                tick();
            end else begin
                check("bp_full_ready", 32'(net_ready), 32'd0);
                check("bp_full_level", 32'(snk_level), 32'd4);
                check("bp_head_hold",  32'(snk),       32'b1000);
            end
        end
        snk_ready = 1'b1;
        #1;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
            if (snk_valid) begin
                if (idx == 2) check("bp_level_pushpop", 32'(snk_level), 32'd3);
                check("bp_drain", 32'(snk), 32'(exp_q[idx]));
                idx++;
            end
            accepted = net_valid && net_ready;
            tick();
            if (accepted) begin
                net_valid = 1'b0;
                net_out   = 4'b0000;
            end
        end
        check("bp_drain_count", 32'(idx),       32'd5);
        check("bp_level_end",   32'(snk_level), 32'd0);
        check("bp_valid_end",   32'(snk_valid), 32'd0);
        check("bp_fifth_taken", 32'(net_valid), 32'd0);

`ifdef SNK_RLE_EN
        // Two zeros then 0010 -> {2, 0100}.
        send(4'b0000);
        check("rle_zero1_valid", 32'(snk_valid), 32'd0);
        send(4'b0000);
        check("rle_zero2_valid", 32'(snk_valid), 32'd0);
        send(4'b0010);
        check("rle_word_valid", 32'(snk_valid), 32'd1);
        check("rle_word",       32'(snk),       32'b10_0100);
        tick();
        check("rle_word_popped", 32'(snk_valid), 32'd0);

        // Saturation: the 4th zero pushes {3,0}; the 5th starts a new run.
        for (int k = 0; k < 3; k++) send(4'b0000);
        check("sat_none_yet", 32'(snk_valid), 32'd0);
        send(4'b0000);
        check("sat_valid", 32'(snk_valid), 32'd1);
        check("sat_word",  32'(snk),       32'b11_0000);
        send(4'b0000);
        check("sat_popped", 32'(snk_valid), 32'd0);
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(net_ready), 32'd0);
        tick();
        check("flush_valid",  32'(snk_valid), 32'd1);
        check("flush_word",   32'(snk),       32'b00_0000);
        check("flush_ready2", 32'(net_ready), 32'd0);
        tick();
        check("flush_once", 32'(snk_valid), 32'd0);
        flush = 1'b0;
        #1;
        check("flush_release_ready", 32'(net_ready), 32'd1);
        tick();
`endif

        // Reset mid-operation discards queued words and any pending run.
        snk_ready = 1'b0;
        send(4'b0001);
        send(4'b0010);
        send(4'b0011);
`ifdef SNK_RLE_EN
        send(4'b0000);
        send(4'b0000);
`endif
        check("mid_level_before", 32'(snk_level), 32'd3);
        #2 arstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(snk_valid), 32'd0);
        check("mid_rst_level", 32'(snk_level), 32'd0);
        check("mid_rst_ready", 32'(net_ready), 32'd1);
        #2 arstn = 1'b1;
        tick();
        check("mid_post_valid", 32'(snk_valid), 32'd0);
        snk_ready = 1'b1;
        send(4'b0100);
        check("mid_next_valid", 32'(snk_valid), 32'd1);
        check("mid_next_word",  32'(snk),       32'b0010);
        tick();
        check("mid_next_popped", 32'(snk_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_buffered_network_sink
